// File: rtl/axi_prewrapper_seq_ctrl_if.sv
// Handshake/bus bundle between the pre-wrapper sequencer, the AXI register
// file, the DUT/DFT handshake ports and the vector address counters.
`default_nettype none

interface axi_prewrapper_seq_ctrl_if #(
  parameter int P_CH = 4
);
  logic [31:0]     ctrl_opcode;
  logic [31:0]     ctrl_config;
  logic [31:0]     ctrl_status;
  logic            dut_val_op;
  logic            dut_op_ack;
  logic            dut_op_commit;
  logic            dut_commit_ack;
  logic            dut_sen;
  logic [P_CH-1:0] dft_val_op;
  logic [P_CH-1:0] dft_op_ack;
  logic [P_CH-1:0] dft_op_commit;
  logic [P_CH-1:0] dft_commit_ack;
  logic [31:0]     in_rdaddr;
  logic            in_rden;
  logic [31:0]     out_wraddr;
  logic            out_wren;
  logic            out_capture;

  modport master (
    input  ctrl_opcode, ctrl_config, dut_op_ack, dut_op_commit,
           dft_op_ack, dft_op_commit,
    output ctrl_status, dut_val_op, dut_commit_ack, dut_sen,
           dft_val_op, dft_commit_ack, in_rdaddr, in_rden,
           out_wraddr, out_wren, out_capture
  );

  modport slave (
    output ctrl_opcode, ctrl_config, dut_op_ack, dut_op_commit,
           dft_op_ack, dft_op_commit,
    input  ctrl_status, dut_val_op, dut_commit_ack, dut_sen,
           dft_val_op, dft_commit_ack, in_rdaddr, in_rden,
           out_wraddr, out_wren, out_capture
  );
endinterface

`default_nettype wire

// File: rtl/axi_prewrapper_seq_ctrl.sv
// Sequencer for the AXI pre-wrapper: input load, functional run, output
// unload and masked multi-chain scan rounds, with watchdog and abort.
`default_nettype none

module axi_prewrapper_seq_ctrl #(
  parameter int P_CH        = 4,
  parameter int P_IN_WORDS  = 8,
  parameter int P_OUT_WORDS = 8,
  parameter int P_TIMEOUT   = 1024
) (
  input  logic                        clk,
  input  logic                        reset,
  axi_prewrapper_seq_ctrl_if.master   bus
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_LOAD      = 4'd1,
    S_DUT_REQ   = 4'd2,
    S_READY     = 4'd3,
    S_RUN_WAIT  = 4'd4,
    S_RUN_DONE  = 4'd5,
    S_UNLOAD    = 4'd6,
    S_SCAN_REQ  = 4'd7,
    S_SCAN_WAIT = 4'd8,
    S_SCAN_DONE = 4'd9,
    S_TICK      = 4'd10,
    S_ERROR     = 4'd11
  } state_t;

  localparam logic [31:0] OP_INPUT = 32'd1;
  localparam logic [31:0] OP_RUN   = 32'd2;
  localparam logic [31:0] OP_ENDR  = 32'd3;
  localparam logic [31:0] OP_TEST  = 32'd4;
  localparam logic [31:0] OP_NEXT  = 32'd5;
  localparam logic [31:0] OP_ENDT  = 32'd6;
  localparam logic [31:0] OP_ABORT = 32'd7;

  localparam logic [31:0] IN_LAST  = 32'(P_IN_WORDS - 1);
  localparam logic [31:0] OUT_LAST = 32'(P_OUT_WORDS - 1);
  localparam logic [31:0] WD_LAST  = 32'(P_TIMEOUT - 1);

  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_MASK    = 2'd2;

  state_t          state_q, state_d;
  logic [31:0]     cnt_q;        // cycles in current state; doubles as word address
  logic [P_CH-1:0] mask_q;
  logic [7:0]      tick_last_q;
  logic [7:0]      round_q;
  logic [1:0]      err_code_q, err_code_d;

  logic [P_CH-1:0] mask_cfg;
  logic            wd_hit;
  logic            all_ack;
  logic            all_commit;
  logic            state_change;
  logic            unused_cfg;

  assign mask_cfg     = bus.ctrl_config[8 +: P_CH];
  assign wd_hit       = (cnt_q == WD_LAST);
  assign all_ack      = ((bus.dft_op_ack    & mask_q) == mask_q);
  assign all_commit   = ((bus.dft_op_commit & mask_q) == mask_q);
  assign state_change = (state_d != state_q);
  assign unused_cfg   = ^bus.ctrl_config[31:24];

  // NOTE: every variable in this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    err_code_d = 2'd0;
    unique case (state_q)
      S_IDLE:      if (bus.ctrl_opcode == OP_INPUT) state_d = S_LOAD;
      S_LOAD:      if (cnt_q == IN_LAST) state_d = S_DUT_REQ;
      S_DUT_REQ: begin
        if (bus.dut_op_ack)  state_d = S_READY;
        else if (wd_hit) begin state_d = S_ERROR; err_code_d = ERR_TIMEOUT; end
      end
      S_READY: begin
        if (bus.ctrl_opcode == OP_RUN) state_d = S_RUN_WAIT;
        else if (bus.ctrl_opcode == OP_TEST) begin
          // An empty chain mask is rejected before any scan request is issued.
          if (mask_cfg == '0) begin state_d = S_ERROR; err_code_d = ERR_MASK; end
          else                state_d = S_SCAN_REQ;
        end
      end
      S_RUN_WAIT: begin
        if (bus.dut_op_commit) state_d = S_RUN_DONE;
        else if (wd_hit) begin state_d = S_ERROR; err_code_d = ERR_TIMEOUT; end
      end
      S_RUN_DONE:  if (bus.ctrl_opcode == OP_ENDR) state_d = S_UNLOAD;
      S_UNLOAD:    if (cnt_q == OUT_LAST) state_d = S_IDLE;
      S_SCAN_REQ: begin
        if (all_ack) state_d = S_SCAN_WAIT;
        else if (wd_hit) begin state_d = S_ERROR; err_code_d = ERR_TIMEOUT; end
      end
      S_SCAN_WAIT: begin
        if (all_commit) state_d = S_SCAN_DONE;
        else if (wd_hit) begin state_d = S_ERROR; err_code_d = ERR_TIMEOUT; end
      end
      S_SCAN_DONE: begin
        if (bus.ctrl_opcode == OP_ENDT)      state_d = S_IDLE;
        else if (bus.ctrl_opcode == OP_NEXT) state_d = S_TICK;
      end
      S_TICK: begin
        if (cnt_q == {24'd0, tick_last_q}) begin
          if (mask_cfg == '0) begin state_d = S_ERROR; err_code_d = ERR_MASK; end
          else                state_d = S_SCAN_REQ;
        end
      end
      S_ERROR:     state_d = S_ERROR;
      default:     state_d = S_IDLE;
    endcase

    // Abort overrides everything, including a watchdog expiry on the same cycle.
    if (bus.ctrl_opcode == OP_ABORT && state_q != S_IDLE) begin
      state_d    = S_IDLE;
      err_code_d = 2'd0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mask_q      <= '0;
      tick_last_q <= '0;
      round_q     <= '0;
      err_code_q  <= '0;
    end else begin
      state_q <= state_d;

      if (state_change)       cnt_q <= '0;
      else if (cnt_q != '1)   cnt_q <= cnt_q + 32'd1;

      if (state_change && state_d == S_SCAN_REQ) mask_q <= mask_cfg;

      if (state_change && state_d == S_TICK)
        tick_last_q <= (bus.ctrl_config[7:0] == 8'd0) ? 8'd0 : bus.ctrl_config[7:0] - 8'd1;

      if (state_change && state_d == S_LOAD)
        round_q <= '0;
      else if (state_q == S_SCAN_WAIT && state_d == S_SCAN_DONE)
        round_q <= round_q + 8'd1;

      if (state_change && state_d == S_ERROR)      err_code_q <= err_code_d;
      else if (state_change && state_q == S_ERROR) err_code_q <= '0;
    end
  end

  always_comb begin
    bus.dut_val_op     = 1'b0;
    bus.dut_commit_ack = 1'b0;
    bus.dut_sen        = 1'b0;
    bus.dft_val_op     = '0;
    bus.dft_commit_ack = '0;
    bus.in_rdaddr      = '0;
    bus.in_rden        = 1'b0;
    bus.out_wraddr     = '0;
    bus.out_wren       = 1'b0;
    bus.out_capture    = 1'b0;
    unique case (state_q)
      S_LOAD:      begin bus.in_rden = 1'b1; bus.in_rdaddr = cnt_q; end
      S_DUT_REQ:   bus.dut_val_op = 1'b1;
      S_READY:     bus.dut_sen = 1'b1;
      S_RUN_DONE:  bus.out_capture = 1'b1;
      S_UNLOAD: begin
        bus.dut_commit_ack = 1'b1;
        bus.out_wren       = 1'b1;
        bus.out_wraddr     = cnt_q;
      end
      S_SCAN_REQ:  begin bus.dut_sen = 1'b1; bus.dft_val_op = mask_q; end
      S_SCAN_WAIT: bus.dut_sen = 1'b1;
      S_SCAN_DONE: begin
        bus.dut_sen        = 1'b1;
        bus.dft_commit_ack = mask_q;
        bus.dut_commit_ack = (bus.ctrl_opcode == OP_ENDT);
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.ctrl_status       = '0;
    bus.ctrl_status[3:0]  = state_q;
    bus.ctrl_status[4]    = (state_q == S_ERROR);
    bus.ctrl_status[6:5]  = err_code_q;
    bus.ctrl_status[14:7] = round_q;
    bus.ctrl_status[15]   = !(state_q inside {S_IDLE, S_READY, S_RUN_DONE, S_SCAN_DONE, S_ERROR});
  end

endmodule

`default_nettype wire

// File: tb/tb_axi_prewrapper_seq_ctrl.sv
// Directed bench for axi_prewrapper_seq_ctrl: load/run/unload, masked scan
// rounds with tick gaps, watchdog, mask error, abort and mid-run reset.
`timescale 1ns/1ps

module tb_axi_prewrapper_seq_ctrl;

  localparam int P_CH = 4;

  localparam logic [31:0] OP_NONE  = 32'd0;
  localparam logic [31:0] OP_INPUT = 32'd1;
  localparam logic [31:0] OP_RUN   = 32'd2;
  localparam logic [31:0] OP_ENDR  = 32'd3;
  localparam logic [31:0] OP_TEST  = 32'd4;
  localparam logic [31:0] OP_NEXT  = 32'd5;
  localparam logic [31:0] OP_ENDT  = 32'd6;
  localparam logic [31:0] OP_ABORT = 32'd7;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  axi_prewrapper_seq_ctrl_if #(.P_CH(P_CH)) bus ();

  axi_prewrapper_seq_ctrl #(
    .P_CH(P_CH), .P_IN_WORDS(8), .P_OUT_WORDS(8), .P_TIMEOUT(16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  wire [77:0] outs_all = {bus.dut_val_op, bus.dut_commit_ack, bus.dut_sen,
                          bus.dft_val_op, bus.dft_commit_ack, bus.in_rdaddr,
                          bus.in_rden, bus.out_wraddr, bus.out_wren, bus.out_capture};
  wire [3:0]  st       = bus.ctrl_status[3:0];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Stimulus only: drive a fresh load and accept the DUT request.
  task automatic go_ready();
    bus.ctrl_opcode = OP_INPUT;
    cyc();
    bus.ctrl_opcode = OP_NONE;
    for (int i = 0; i < 20 && st != 4'd2; i++) cyc();
    bus.dut_op_ack = 1'b1;
    cyc();
    bus.dut_op_ack = 1'b0;
    if (st != 4'd3) begin
      total++; bad++;
      $display("FAIL go_ready: state=%0d required=3", st);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc(); cyc();
    reset = 1'b0;
    cyc();
    total++; if (bus.ctrl_status !== 32'd0) begin bad++; $display("FAIL reset_status: got=%h exp=%h", bus.ctrl_status, 32'd0); end
    total++; if (outs_all !== 78'd0) begin bad++; $display("FAIL reset_outs: got=%h exp=0", outs_all); end
  endtask

  task automatic test_load();
    bus.ctrl_opcode = OP_INPUT;
    for (int i = 0; i < 8; i++) begin
      cyc();
      bus.ctrl_opcode = OP_NONE;
      total++; if (st !== 4'd1 || bus.in_rden !== 1'b1 || bus.in_rdaddr !== 32'(i) || bus.ctrl_status[15] !== 1'b1) begin
        bad++; $display("FAIL load_word%0d: state=%0d rden=%b addr=%0d", i, st, bus.in_rden, bus.in_rdaddr);
      end
    end
    cyc(); cyc(); cyc();
    total++; if (st !== 4'd2 || bus.dut_val_op !== 1'b1 || bus.in_rden !== 1'b0) begin
      bad++; $display("FAIL dut_req: state=%0d val_op=%b rden=%b exp 2/1/0", st, bus.dut_val_op, bus.in_rden);
    end
    bus.dut_op_ack = 1'b1;
    cyc();
    bus.dut_op_ack = 1'b0;
    total++; if (bus.ctrl_status !== 32'h3 || bus.dut_sen !== 1'b1 || bus.dut_val_op !== 1'b0) begin
      bad++; $display("FAIL ready: status=%h sen=%b exp status=00000003 sen=1", bus.ctrl_status, bus.dut_sen);
    end
  endtask

  task automatic test_run();
    bus.ctrl_opcode = OP_RUN;
    for (int i = 0; i < 5; i++) begin
      cyc();
      bus.ctrl_opcode = OP_NONE;
    end
    total++; if (st !== 4'd4 || bus.ctrl_status[15] !== 1'b1 || bus.out_capture !== 1'b0) begin
      bad++; $display("FAIL run_wait: state=%0d busy=%b exp 4/1", st, bus.ctrl_status[15]);
    end
    bus.dut_op_commit = 1'b1;
    cyc();
    bus.dut_op_commit = 1'b0;
    cyc();
    total++; if (st !== 4'd5 || bus.out_capture !== 1'b1 || bus.ctrl_status[15] !== 1'b0) begin
      bad++; $display("FAIL run_done: state=%0d capture=%b exp 5/1", st, bus.out_capture);
    end
    bus.ctrl_opcode = OP_ENDR;
    for (int i = 0; i < 8; i++) begin
      cyc();
      bus.ctrl_opcode = OP_NONE;
      total++; if (st !== 4'd6 || bus.out_wren !== 1'b1 || bus.dut_commit_ack !== 1'b1 || bus.out_wraddr !== 32'(i)) begin
        bad++; $display("FAIL unload_word%0d: state=%0d wren=%b addr=%0d", i, st, bus.out_wren, bus.out_wraddr);
      end
    end
    cyc();
    total++; if (bus.ctrl_status !== 32'd0 || outs_all !== 78'd0) begin
      bad++; $display("FAIL run_back_idle: status=%h outs=%h exp 0", bus.ctrl_status, outs_all);
    end
  endtask

  task automatic test_scan();
    go_ready();
    bus.ctrl_config = {8'd0, 16'h0005, 8'd4};
    bus.ctrl_opcode = OP_TEST;
    cyc();
    bus.ctrl_opcode = OP_NONE;
    total++; if (st !== 4'd7 || bus.dft_val_op !== 4'b0101 || bus.dut_sen !== 1'b1) begin
      bad++; $display("FAIL scan_req: state=%0d val_op=%b exp 7/0101", st, bus.dft_val_op);
    end
    bus.dft_op_ack = 4'b0001;
    cyc();
    total++; if (st !== 4'd7) begin bad++; $display("FAIL scan_partial_ack: state=%0d exp 7", st); end
    bus.dft_op_ack = 4'b1101;
    cyc();
    bus.dft_op_ack = 4'b0000;
    total++; if (st !== 4'd8 || bus.dft_val_op !== 4'b0000 || bus.dut_sen !== 1'b1) begin
      bad++; $display("FAIL scan_wait: state=%0d val_op=%b exp 8/0000", st, bus.dft_val_op);
    end
    bus.dft_op_commit = 4'b0100;
    cyc();
    total++; if (st !== 4'd8) begin bad++; $display("FAIL scan_partial_commit: state=%0d exp 8", st); end
    bus.dft_op_commit = 4'b0111;
    cyc();
    bus.dft_op_commit = 4'b0000;
    total++; if (bus.ctrl_status !== 32'h89 || bus.dft_commit_ack !== 4'b0101) begin
      bad++; $display("FAIL scan_done: status=%h cack=%b exp 00000089/0101", bus.ctrl_status, bus.dft_commit_ack);
    end
  endtask

  // Starts in SCAN_DONE with round count 1 and tick=4.
  task automatic test_tick();
    for (int r = 0; r < 3; r++) begin
      bus.ctrl_opcode = OP_NEXT;
      cyc();
      bus.ctrl_opcode = OP_NONE;
      for (int k = 0; k < 4; k++) begin
        if (k != 0) cyc();
        total++; if (st !== 4'd10 || bus.dut_sen !== 1'b0) begin
          bad++; $display("FAIL tick_r%0d_c%0d: state=%0d sen=%b exp 10/0", r, k, st, bus.dut_sen);
        end
      end
      cyc();
      total++; if (st !== 4'd7 || bus.dut_sen !== 1'b1) begin
        bad++; $display("FAIL tick_end_r%0d: state=%0d sen=%b exp 7/1", r, st, bus.dut_sen);
      end
      bus.dft_op_ack = 4'b0101; cyc(); bus.dft_op_ack = 4'b0000;
      bus.dft_op_commit = 4'b0101; cyc(); bus.dft_op_commit = 4'b0000;
    end
    total++; if (st !== 4'd9 || bus.ctrl_status[14:7] !== 8'd4) begin
      bad++; $display("FAIL round_count4: state=%0d rounds=%0d exp 9/4", st, bus.ctrl_status[14:7]);
    end
    bus.ctrl_config = {8'd0, 16'h0005, 8'd0};
    bus.ctrl_opcode = OP_NEXT;
    cyc();
    bus.ctrl_opcode = OP_NONE;
    total++; if (st !== 4'd10) begin bad++; $display("FAIL tick0_enter: state=%0d exp 10", st); end
    cyc();
    total++; if (st !== 4'd7) begin bad++; $display("FAIL tick0_len: state=%0d exp 7", st); end
    bus.dft_op_ack = 4'b0101; cyc(); bus.dft_op_ack = 4'b0000;
    bus.dft_op_commit = 4'b0101; cyc(); bus.dft_op_commit = 4'b0000;
    bus.ctrl_opcode = OP_ENDT;
    #1;
    total++; if (bus.dut_commit_ack !== 1'b1 || bus.dft_commit_ack !== 4'b0101) begin
      bad++; $display("FAIL endt_ack: cack=%b dft_cack=%b exp 1/0101", bus.dut_commit_ack, bus.dft_commit_ack);
    end
    cyc();
    bus.ctrl_opcode = OP_NONE;
    total++; if (bus.ctrl_status !== 32'h280 || outs_all !== 78'd0) begin
      bad++; $display("FAIL endt_idle: status=%h exp 00000280", bus.ctrl_status);
    end
  endtask

  task automatic test_timeout();
    go_ready();
    bus.ctrl_config = {8'd0, 16'h0005, 8'd1};
    bus.ctrl_opcode = OP_TEST;
    cyc();
    bus.ctrl_opcode = OP_NONE;
    bus.dft_op_ack = 4'b0101;
    cyc();
    bus.dft_op_ack = 4'b0000;
    for (int i = 0; i < 15; i++) cyc();
    total++; if (st !== 4'd8) begin bad++; $display("FAIL timeout_early: state=%0d exp 8", st); end
    cyc();
    total++; if (bus.ctrl_status !== 32'h3B || outs_all !== 78'd0) begin
      bad++; $display("FAIL timeout_error: status=%h outs=%h exp 0000003b/0", bus.ctrl_status, outs_all);
    end
    cyc();
    total++; if (st !== 4'd11) begin bad++; $display("FAIL error_hold: state=%0d exp 11", st); end
    bus.ctrl_opcode = OP_ABORT;
    cyc();
    bus.ctrl_opcode = OP_NONE;
    total++; if (bus.ctrl_status !== 32'd0) begin bad++; $display("FAIL error_abort: status=%h exp 0", bus.ctrl_status); end
  endtask

  task automatic test_wd_race();
    bus.ctrl_opcode = OP_INPUT;
    cyc();
    bus.ctrl_opcode = OP_NONE;
    for (int i = 0; i < 8; i++) cyc();
    total++; if (st !== 4'd2) begin bad++; $display("FAIL race_dut_req: state=%0d exp 2", st); end
    for (int i = 0; i < 15; i++) cyc();
    bus.dut_op_ack = 1'b1;
    cyc();
    bus.dut_op_ack = 1'b0;
    total++; if (bus.ctrl_status !== 32'h3) begin bad++; $display("FAIL race_ack_wins: status=%h exp 00000003", bus.ctrl_status); end
  endtask

  // Starts in READY.
  task automatic test_mask_zero();
    bus.ctrl_config = {8'd0, 16'h0000, 8'd1};
    bus.ctrl_opcode = OP_TEST;
    cyc();
    bus.ctrl_opcode = OP_NONE;
    total++; if (bus.ctrl_status !== 32'h5B || bus.dft_val_op !== 4'b0000) begin
      bad++; $display("FAIL mask_zero: status=%h val_op=%b exp 0000005b/0000", bus.ctrl_status, bus.dft_val_op);
    end
    bus.ctrl_opcode = OP_ABORT;
    cyc();
    bus.ctrl_opcode = OP_NONE;
    total++; if (bus.ctrl_status !== 32'd0) begin bad++; $display("FAIL mask_zero_abort: status=%h exp 0", bus.ctrl_status); end
  endtask

  task automatic test_abort_load();
    bus.ctrl_opcode = OP_INPUT;
    cyc();
    bus.ctrl_opcode = OP_NONE;
    cyc(); cyc(); cyc();
    total++; if (bus.in_rdaddr !== 32'd3) begin bad++; $display("FAIL abort_load_word3: addr=%0d exp 3", bus.in_rdaddr); end
    bus.ctrl_opcode = OP_ABORT;
    cyc();
    bus.ctrl_opcode = OP_NONE;
    total++; if (bus.ctrl_status !== 32'd0 || outs_all !== 78'd0) begin
      bad++; $display("FAIL abort_load_idle: status=%h outs=%h exp 0", bus.ctrl_status, outs_all);
    end
    cyc();
    total++; if (st !== 4'd0) begin bad++; $display("FAIL abort_load_stay: state=%0d exp 0", st); end
  endtask

  task automatic test_reset_mid();
    go_ready();
    bus.ctrl_config = {8'd0, 16'h0005, 8'd0};
    bus.ctrl_opcode = OP_TEST;
    cyc();
    bus.ctrl_opcode = OP_NONE;
    bus.dft_op_ack = 4'b0101; cyc(); bus.dft_op_ack = 4'b0000;
    bus.dft_op_commit = 4'b0101; cyc(); bus.dft_op_commit = 4'b0000;
    bus.ctrl_opcode = OP_NEXT; cyc(); bus.ctrl_opcode = OP_NONE;
    cyc();
    bus.dft_op_ack = 4'b0101; cyc(); bus.dft_op_ack = 4'b0000;
    total++; if (st !== 4'd8 || bus.ctrl_status[14:7] !== 8'd1) begin
      bad++; $display("FAIL pre_reset: state=%0d rounds=%0d exp 8/1", st, bus.ctrl_status[14:7]);
    end
    bus.dft_op_commit = 4'b0001;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    bus.dft_op_commit = 4'b0000;
    total++; if (bus.ctrl_status !== 32'd0 || outs_all !== 78'd0) begin
      bad++; $display("FAIL reset_mid: status=%h outs=%h exp 0", bus.ctrl_status, outs_all);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.ctrl_opcode   = OP_NONE;
    bus.ctrl_config   = 32'd0;
    bus.dut_op_ack    = 1'b0;
    bus.dut_op_commit = 1'b0;
    bus.dft_op_ack    = '0;
    bus.dft_op_commit = '0;

    test_reset();
    test_load();
    test_run();
    test_scan();
    test_tick();
    test_timeout();
    test_wd_race();
    test_mask_zero();
    test_abort_load();
    test_reset_mid();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
